channel_loader: RTL and testbench
=================================

# channel_loader

Input-side frame loader for the 4x4 complex-channel bidiagonalization engine. It accepts channel coefficients from the estimator as a gapped, column-major, valid/ready stream and buffers them in a two-bank ping-pong store. It then replays each complete 16-element frame to the bidiagonalization core as one contiguous, row-major burst of 16 valid cycles. The core requires this burst shape: it latches one element per valid cycle and starts processing on the first cycle valid drops.

## Interface
- BIT_NUM, 18, width of each real/imag sample (signed two's complement)
- GAP_CYCLES, 4, minimum idle cycles on out_valid between consecutive bursts (range 1..15)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  upstream sample valid
- in_ready  output  1  loader can accept a sample this cycle
- in_sof  input  1  marks element 0 (row 0, col 0) of a frame
- in_R  input  BIT_NUM  real part, signed
- in_I  input  BIT_NUM  imaginary part, signed
- ds_ready  input  1  downstream core is idle and may receive a burst
- out_valid  output  1  burst element valid; maps to the core's valid_i
- out_R  output  BIT_NUM  real part to the core's R_i
- out_I  output  BIT_NUM  imaginary part to the core's I_i
- frame_err  output  1  one-cycle pulse when a malformed frame is discarded

## Operation
- **Input ordering.** Input element k (0..15) is column-major: row = k%4, col = k/4. It is stored at bank address k.
- **Output ordering.** Output element n (0..15) is row-major: row = n/4, col = n%4. It is read from bank address (n%4)*4 + n/4.
- **Banks.** Bank 0 and bank 1 each have a status of FREE, FILLING or FULL.
  - wr_bank and rd_bank are 1-bit pointers and start at 0.
  - Banks are consumed in fill order.
- **Accept.** A handshake is in_valid & in_ready. in_ready = 1 iff the bank at wr_bank is not FULL.
- **Write counter.** wr_cnt is 4 bits, with a separate "frame open" flag.
  - Handshake with in_sof=1 while a frame is open: discard the partial frame, pulse frame_err, write the sample at address 0, set wr_cnt=1.
  - Handshake with in_sof=1 while no frame is open: write at address 0, set wr_cnt=1, open the frame.
  - Handshake with in_sof=0 while no frame is open: drop the sample and pulse frame_err.
  - Otherwise: write at address wr_cnt and increment wr_cnt.
  - On the 16th write: mark the bank FULL, close the frame, toggle wr_bank, clear wr_cnt.
- **Output FSM** (IDLE, SEND, GAP):
  - IDLE → SEND when the bank at rd_bank is FULL and ds_ready=1.
  - SEND runs for 16 cycles with rd_cnt 0..15. After rd_cnt=15: mark the bank FREE, toggle rd_bank, go to GAP.
  - GAP counts GAP_CYCLES cycles, then returns to IDLE.
  - ds_ready is sampled only in IDLE. Dropping ds_ready during SEND does not interrupt the burst.
- **Data path.** No arithmetic; samples pass bit-exact.

## Timing
- **Reset values.** out_valid=0, out_R=0, out_I=0, frame_err=0. Both banks FREE, pointers 0, counters 0, FSM IDLE. in_ready=1 from the first cycle after reset.
- **Registered outputs.** out_valid, out_R, out_I and frame_err are all registered.
- **Burst start.** IDLE sees a FULL bank and ds_ready=1 at cycle t. Then out_valid=1 for cycles t+1..t+16 exactly, with no holes, and out_valid=0 at t+17.
- **Min latency.** 16th input handshake at cycle t → bank FULL at t+1 → out_valid first high at t+2, provided ds_ready=1.
- **Burst spacing.** At least GAP_CYCLES low cycles of out_valid separate consecutive bursts.
- **Bank release.**
  - The freed bank can accept input in the cycle after the last burst element is presented.
  - A write into bank A and a read from bank B in the same cycle is legal.
- **Both banks FULL.** in_ready=0 until the burst in progress completes.
- **Outputs outside SEND.** out_R and out_I are 0 whenever out_valid=0.
- **frame_err.** Asserted the cycle after the offending handshake, for exactly one cycle.
- **Reset mid-operation.**
  - rst during SEND truncates the burst: out_valid=0 on the next cycle.
  - All buffered and partial frames are lost.
  - No frame_err is raised.

## Test plan
- **Single frame.** Reset, then 16 back-to-back samples k=0..15 with R=k, I=-k, in_sof on k=0, ds_ready=1. Required: out_valid high for exactly 16 cycles starting 2 cycles after the last input; out_R sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_I is the negation of each.
- **Gapped input.** in_valid toggled randomly at 50%. Required: the output burst is still 16 contiguous cycles with the same transposed order.
- **Ping-pong / back-pressure.** Three frames sent back-to-back with ds_ready=0. Required: in_ready drops after 32 accepts. Then raise ds_ready. Required: bursts emitted in frame order, separated by exactly GAP_CYCLES=4 idle cycles; the third frame is accepted once bank 0 is freed.
- **Malformed frames.**
  - in_sof reasserted at k=7: frame_err pulses once and the frame restarts.
  - A non-sof sample arriving with no frame open: frame_err pulses once and the sample is dropped.
  - In both cases the next burst contains only the new frame's 16 values.
- **Downstream gating.** ds_ready held 0 for 50 cycles after a frame is FULL. Required: no out_valid; the burst starts 1 cycle after ds_ready rises. ds_ready dropped mid-burst: all 16 elements are still emitted.
- **Reset mid-burst.** rst asserted at burst element 5. Required: out_valid=0 the next cycle, in_ready=1, and a fresh frame afterwards transfers correctly.

Source files
------------

// File: rtl/channel_loader.sv
// channel_loader
//   Ping-pong frame buffer between the channel estimator and the 4x4
//   bidiagonalization core. Accepts a gapped, column-major valid/ready stream
//   of complex samples and replays each complete 16-element frame as one
//   contiguous row-major burst of 16 valid cycles.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_sof marks element 0 of a frame
//   in_R, in_I        upstream sample (signed, BIT_NUM bits each)
//   ds_ready          core idle, may receive a burst
//   out_valid         burst element valid (registered)
//   out_R, out_I      burst element, zero whenever out_valid is low
//   frame_err         one-cycle pulse when a malformed frame/sample is dropped
//
// Output FSM
//   state  | meaning
//   S_IDLE | waiting for a FULL bank at rd_bank and ds_ready
//   S_SEND | presenting element rd_cnt of the burst (16 cycles)
//   S_GAP  | enforcing the idle spacing between bursts
module channel_loader #(
  parameter int BIT_NUM    = 18,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sof,
  input  logic signed [BIT_NUM-1:0] in_R,
  input  logic signed [BIT_NUM-1:0] in_I,
  input  logic                      ds_ready,
  output logic                      out_valid,
  output logic signed [BIT_NUM-1:0] out_R,
  output logic signed [BIT_NUM-1:0] out_I,
  output logic                      frame_err
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bank_st_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic signed [BIT_NUM-1:0] mem_r [2][16];
  logic signed [BIT_NUM-1:0] mem_i [2][16];

  bank_st_t   bank_st [2];
  logic       wr_bank;
  logic       rd_bank;
  logic [3:0] wr_cnt;
  logic       frame_open;
  state_t     state;
  logic [3:0] rd_cnt;
  logic [3:0] gap_cnt;

  logic       wr_fire;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic       launch;
  logic [3:0] rd_next;

  // Row-major element n lives at column-major address (n%4)*4 + n/4.
  function automatic logic [3:0] rd_addr(input logic [3:0] n);
    return {n[1:0], n[3:2]};
  endfunction

  assign in_ready = (bank_st[wr_bank] != B_FULL);
  assign wr_fire  = in_valid & in_ready;
  // A non-sof sample with no open frame is dropped, never written.
  assign wr_en    = wr_fire & (in_sof | frame_open);
  assign wr_addr  = in_sof ? 4'd0 : wr_cnt;
  assign launch   = (bank_st[rd_bank] == B_FULL) & ds_ready;
  assign rd_next  = rd_cnt + 4'd1;

  // Sample storage carries no reset; validity is tracked by bank_st.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_bank][wr_addr] <= in_R;
      mem_i[wr_bank][wr_addr] <= in_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= 4'd0;
      frame_open <= 1'b0;
      state      <= S_IDLE;
      rd_cnt     <= 4'd0;
      gap_cnt    <= 4'd0;
      out_valid  <= 1'b0;
      out_R      <= '0;
      out_I      <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // Write side
      if (wr_fire) begin
        if (in_sof) begin
          // A restart inside an open frame discards the partial frame.
          frame_err        <= frame_open;
          frame_open       <= 1'b1;
          wr_cnt           <= 4'd1;
          bank_st[wr_bank] <= B_FILLING;
        end else if (!frame_open) begin
          frame_err <= 1'b1;
        end else if (wr_cnt == 4'd15) begin
          bank_st[wr_bank] <= B_FULL;
          frame_open       <= 1'b0;
          wr_bank          <= ~wr_bank;
          wr_cnt           <= 4'd0;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end

      // Read side. The bank being read is FULL, so the write side can never
      // touch the same bank_st entry in this cycle.
      case (state)
        S_IDLE: begin
          if (launch) begin
            state     <= S_SEND;
            rd_cnt    <= 4'd0;
            out_valid <= 1'b1;
            out_R     <= mem_r[rd_bank][4'd0];
            out_I     <= mem_i[rd_bank][4'd0];
          end
        end
        S_SEND: begin
          if (rd_cnt == 4'd15) begin
            bank_st[rd_bank] <= B_FREE;
            rd_bank          <= ~rd_bank;
            out_valid        <= 1'b0;
            out_R            <= '0;
            out_I            <= '0;
            gap_cnt          <= GAP_LOAD;
            state            <= S_GAP;
          end else begin
            rd_cnt <= rd_next;
            out_R  <= mem_r[rd_bank][rd_addr(rd_next)];
            out_I  <= mem_i[rd_bank][rd_addr(rd_next)];
          end
        end
        S_GAP: begin
          // The terminal gap cycle doubles as the launch decision so the
          // low time between bursts is exactly GAP_CYCLES.
          if (gap_cnt == 4'd0) begin
            if (launch) begin
              state     <= S_SEND;
              rd_cnt    <= 4'd0;
              out_valid <= 1'b1;
              out_R     <= mem_r[rd_bank][4'd0];
              out_I     <= mem_i[rd_bank][4'd0];
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_loader.sv
// tb_channel_loader
//   Directed bench for channel_loader: reset values, single frame transpose,
//   gapped input, ping-pong back-pressure, malformed frames, downstream
//   gating and reset in the middle of a burst.
module tb_channel_loader;
  localparam int BIT_NUM    = 18;
  localparam int GAP_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic ds_ready = 1'b0;
  logic in_ready, out_valid, frame_err;
  logic signed [BIT_NUM-1:0] in_R = '0;
  logic signed [BIT_NUM-1:0] in_I = '0;
  logic signed [BIT_NUM-1:0] out_R, out_I;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int timeouts = 0;
  int zero_viol = 0;
  int err_pulses = 0;
  int first_hs = 0;
  int last_hs = 0;

  logic [BIT_NUM-1:0] cap_R[$];
  logic [BIT_NUM-1:0] cap_I[$];
  int                 cap_cyc[$];

  channel_loader #(.BIT_NUM(BIT_NUM), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_R(in_R), .in_I(in_I),
    .ds_ready(ds_ready),
    .out_valid(out_valid), .out_R(out_R), .out_I(out_I),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_R.push_back(out_R);
      cap_I.push_back(out_I);
      cap_cyc.push_back(cyc);
    end else if (out_R !== '0 || out_I !== '0) begin
      zero_viol++;
    end
    if (frame_err) err_pulses++;
  end

  task automatic clear_caps();
    cap_R.delete();
    cap_I.delete();
    cap_cyc.delete();
    err_pulses = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_caps();
  endtask

  task automatic push(input logic sof, input int v);
    int n;
    n = 0;
    in_valid = 1'b1; in_sof = sof;
    in_R = BIT_NUM'(v); in_I = BIT_NUM'(-v);
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) timeouts++;
    @(posedge clk);
    last_hs = cyc;
    #1 in_sof = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gapped);
    for (int k = 0; k < 16; k++) begin
      if (gapped && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      push(k == 0, base + k);
      if (k == 0) first_hs = last_hs;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int limit, output bit ok);
    int i;
    i = 0;
    while (cap_R.size() < n && i < limit) begin
      @(posedge clk); #1; i++;
    end
    ok = (cap_R.size() >= n);
  endtask

  // Counts element mismatches and holes in the burst starting at idx.
  function automatic int burst_errs(input int idx, input int base);
    int e, k;
    e = 0;
    if (cap_R.size() < idx + 16) return 99;
    for (int n = 0; n < 16; n++) begin
      k = (n % 4) * 4 + n / 4;
      if (cap_R[idx+n] !== BIT_NUM'(base + k)) e++;
      if (cap_I[idx+n] !== BIT_NUM'(-(base + k))) e++;
      if (n > 0 && cap_cyc[idx+n] != cap_cyc[idx+n-1] + 1) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_R !== '0) $display("FAIL reset_out_R got=%0d exp=0", out_R);
    else pass_cnt++;
    total_cnt++;
    if (out_I !== '0) $display("FAIL reset_out_I got=%0d exp=0", out_I);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_frame();
    bit ok;
    int k;
    do_reset();
    ds_ready = 1'b1;
    send_frame(0, 1'b0);
    wait_caps(16, 60, ok);
    total_cnt++;
    if (!ok) $display("FAIL single_timeout got=%0d elements exp=16", cap_R.size());
    else pass_cnt++;
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (cap_R.size() != 16) $display("FAIL single_len got=%0d exp=16", cap_R.size());
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[0] != last_hs + 2)
      $display("FAIL single_latency got=%0d exp=%0d", cap_cyc[0], last_hs + 2);
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[15] != last_hs + 17)
      $display("FAIL single_last_cycle got=%0d exp=%0d", cap_cyc[15], last_hs + 17);
    else pass_cnt++;
    for (int n = 0; n < 16; n++) begin
      k = (n % 4) * 4 + n / 4;
      total_cnt++;
      if (cap_R[n] !== BIT_NUM'(k))
        $display("FAIL single_R[%0d] got=%0d exp=%0d", n, cap_R[n], k);
      else pass_cnt++;
      total_cnt++;
      if (cap_I[n] !== BIT_NUM'(-k))
        $display("FAIL single_I[%0d] got=%0h exp=%0h", n, cap_I[n], BIT_NUM'(-k));
      else pass_cnt++;
    end
  endtask

  task automatic test_gapped();
    bit ok;
    int e;
    do_reset();
    ds_ready = 1'b1;
    send_frame(100, 1'b1);
    wait_caps(16, 80, ok);
    repeat (4) @(posedge clk);
    #1;
    e = burst_errs(0, 100);
    total_cnt++;
    if (e != 0) $display("FAIL gapped_burst got=%0d errors exp=0", e);
    else pass_cnt++;
    total_cnt++;
    if (cap_R.size() != 16) $display("FAIL gapped_len got=%0d exp=16", cap_R.size());
    else pass_cnt++;
  endtask

  task automatic test_ping_pong();
    bit ok;
    int e;
    do_reset();
    ds_ready = 1'b0;
    send_frame(200, 1'b0);
    send_frame(300, 1'b0);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL pp_in_ready_full got=%b exp=0", in_ready);
    else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || cap_R.size() != 0)
      $display("FAIL pp_hold got in_ready=%b out=%0d exp in_ready=0 out=0", in_ready, cap_R.size());
    else pass_cnt++;
    ds_ready = 1'b1;
    send_frame(400, 1'b0);
    wait_caps(48, 200, ok);
    total_cnt++;
    if (!ok) $display("FAIL pp_timeout got=%0d elements exp=48", cap_R.size());
    else pass_cnt++;
    total_cnt++;
    if (first_hs != cap_cyc[15] + 1)
      $display("FAIL pp_release got=%0d exp=%0d", first_hs, cap_cyc[15] + 1);
    else pass_cnt++;
    e = burst_errs(0, 200) + burst_errs(16, 300) + burst_errs(32, 400);
    total_cnt++;
    if (e != 0) $display("FAIL pp_order got=%0d errors exp=0", e);
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[16] - cap_cyc[15] - 1 != GAP_CYCLES)
      $display("FAIL pp_gap1 got=%0d exp=%0d", cap_cyc[16] - cap_cyc[15] - 1, GAP_CYCLES);
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[32] - cap_cyc[31] - 1 != GAP_CYCLES)
      $display("FAIL pp_gap2 got=%0d exp=%0d", cap_cyc[32] - cap_cyc[31] - 1, GAP_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_malformed();
    bit ok;
    int e;
    do_reset();
    ds_ready = 1'b1;
    for (int k = 0; k < 7; k++) push(k == 0, 500 + k);
    push(1'b1, 600);
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL mal_sof_err got=%b exp=1", frame_err);
    else pass_cnt++;
    for (int k = 1; k < 16; k++) push(1'b0, 600 + k);
    in_valid = 1'b0;
    wait_caps(16, 60, ok);
    repeat (8) @(posedge clk);
    #1;
    e = burst_errs(0, 600);
    total_cnt++;
    if (e != 0 || cap_R.size() != 16)
      $display("FAIL mal_sof_burst got=%0d errors len=%0d exp 0 errors len=16", e, cap_R.size());
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != 1) $display("FAIL mal_sof_pulses got=%0d exp=1", err_pulses);
    else pass_cnt++;

    clear_caps();
    push(1'b0, 999);
    in_valid = 1'b0;
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL mal_orphan_err got=%b exp=1", frame_err);
    else pass_cnt++;
    send_frame(700, 1'b0);
    wait_caps(16, 60, ok);
    repeat (8) @(posedge clk);
    #1;
    e = burst_errs(0, 700);
    total_cnt++;
    if (e != 0 || cap_R.size() != 16)
      $display("FAIL mal_orphan_burst got=%0d errors len=%0d exp 0 errors len=16", e, cap_R.size());
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != 1) $display("FAIL mal_orphan_pulses got=%0d exp=1", err_pulses);
    else pass_cnt++;
  endtask

  task automatic test_ds_gating();
    bit ok;
    int r, e;
    do_reset();
    ds_ready = 1'b0;
    send_frame(800, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    total_cnt++;
    if (cap_R.size() != 0) $display("FAIL gate_hold got=%0d exp=0", cap_R.size());
    else pass_cnt++;
    ds_ready = 1'b1;
    r = cyc;
    wait_caps(4, 20, ok);
    ds_ready = 1'b0;
    wait_caps(16, 40, ok);
    repeat (6) @(posedge clk);
    #1;
    total_cnt++;
    if (cap_cyc[0] != r + 1) $display("FAIL gate_start got=%0d exp=%0d", cap_cyc[0], r + 1);
    else pass_cnt++;
    e = burst_errs(0, 800);
    total_cnt++;
    if (e != 0 || cap_R.size() != 16)
      $display("FAIL gate_burst got=%0d errors len=%0d exp 0 errors len=16", e, cap_R.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int e;
    do_reset();
    ds_ready = 1'b1;
    send_frame(900, 1'b0);
    wait_caps(5, 40, ok);
    total_cnt++;
    if (out_valid !== 1'b1 || out_R !== BIT_NUM'(905))
      $display("FAIL rmb_elem5 got valid=%b R=%0d exp valid=1 R=905", out_valid, out_R);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rmb_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rmb_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    clear_caps();
    send_frame(1000, 1'b0);
    wait_caps(16, 60, ok);
    repeat (8) @(posedge clk);
    #1;
    e = burst_errs(0, 1000);
    total_cnt++;
    if (e != 0 || cap_R.size() != 16)
      $display("FAIL rmb_fresh got=%0d errors len=%0d exp 0 errors len=16", e, cap_R.size());
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != 0) $display("FAIL rmb_frame_err got=%0d exp=0", err_pulses);
    else pass_cnt++;
  endtask

  task automatic test_sanity();
    total_cnt++;
    if (timeouts != 0) $display("FAIL input_timeouts got=%0d exp=0", timeouts);
    else pass_cnt++;
    total_cnt++;
    if (zero_viol != 0) $display("FAIL idle_data_nonzero got=%0d exp=0", zero_viol);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_ping_pong();
    test_malformed();
    test_ds_gating();
    test_reset_mid_burst();
    test_sanity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
